// File: rtl/writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared types and constants for the register-file write-back path.
//   REG_W / DATA_W / NUM_REGS : register file geometry (32 x 32)
//   wb_req_t                  : one pending write {destination register, data}
//   grant_e                   : which source owns the write port this cycle
//   reg_onehot()              : destination register -> one-hot bit vector
// -----------------------------------------------------------------------------
package writeback_arbiter_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_W-1:0]  wr_reg;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MD   = 2'd2
    } grant_e;

    // One-hot decode of a destination register number.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO holding multiply/divide write-back requests.
// No bypass: an entry pushed at an edge is visible at the head only afterwards.
// Ports:
//   clock, ctrl_reset_n     : clock, asynchronous active-low reset
//   push_i / push_req_i     : enqueue request (ignored when full)
//   pop_i                   : dequeue head (ignored when empty)
//   head_o                  : oldest entry
//   count_o, full_o, empty_o: occupancy status
//   entry_valid_o           : per-slot occupied flag
//   entry_reg_o             : per-slot destination register (for hazard mask)
// -----------------------------------------------------------------------------
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clock,
    input  logic                        ctrl_reset_n,
    input  logic                        push_i,
    input  wb_req_t                     push_req_i,
    input  logic                        pop_i,
    output wb_req_t                     head_o,
    output logic [CNT_W-1:0]            count_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [DEPTH-1:0]            entry_valid_o,
    output logic [DEPTH-1:0][REG_W-1:0] entry_reg_o
);

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign full_o        = (count_q == CNT_W'(DEPTH));
    assign empty_o       = (count_q == CNT_W'(0));
    assign count_o       = count_q;
    assign head_o        = mem_q[rd_ptr_q];
    assign entry_valid_o = valid_q;

    // Qualified push/pop so misuse can never corrupt the pointers.
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Expose each slot's destination register for the pending mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_reg_o[i] = mem_q[i].wr_reg;
        end
    end

    // Next-state for pointers, count and per-slot valid flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (do_push_s) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        // Push and pop never target the same slot: that would need full or empty.
        if (do_pop_s) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every queued entry.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            valid_q  <= DEPTH'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; only the slot under the write pointer changes.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Owns the register file's single write port. Single-cycle ALU results go
// straight through; multi-cycle multiply/divide results are buffered in a FIFO.
// The ALU has priority, but after STARVE_LIMIT consecutive ALU wins with the
// FIFO non-empty the FIFO head is forced through for one cycle.
// Ports:
//   clock, ctrl_reset_n                 : clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_reg/alu_data: ALU result handshake
//   md_valid/md_ready/md_reg/md_data    : multdiv result handshake (into FIFO)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered RF write port
//   pending_mask                        : registers with writes still queued
//   fifo_count                          : FIFO occupancy
// -----------------------------------------------------------------------------
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int STARVE_LIMIT = 3,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int SCNT_W       = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clock,
    input  logic                ctrl_reset_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                md_valid,
    output logic                md_ready,
    input  logic [REG_W-1:0]    md_reg,
    input  logic [DATA_W-1:0]   md_data,
    output logic                ctrl_writeEnable,
    output logic [REG_W-1:0]    ctrl_writeReg,
    output logic [DATA_W-1:0]   data_writeReg,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    fifo_count
);

    wb_req_t                      md_req_s;
    wb_req_t                      head_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic [DEPTH-1:0]             entry_valid_s;
    logic [DEPTH-1:0][REG_W-1:0]  entry_reg_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         force_md_s;
    grant_e                       grant_s;

    logic [SCNT_W-1:0]            starve_q, starve_d;
    logic                         we_q, we_d;
    logic [REG_W-1:0]             wreg_q, wreg_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;

    assign md_req_s = '{wr_reg: md_reg, data: md_data};

    // md_ready comes from registered occupancy only, so a same-cycle pop
    // never opens a slot for a same-cycle push.
    assign md_ready = !fifo_full_s;
    assign push_s   = md_valid && md_ready;
    assign pop_s    = (grant_s == GNT_MD);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock         (clock),
        .ctrl_reset_n  (ctrl_reset_n),
        .push_i        (push_s),
        .push_req_i    (md_req_s),
        .pop_i         (pop_s),
        .head_o        (head_s),
        .count_o       (fifo_count),
        .full_o        (fifo_full_s),
        .empty_o       (fifo_empty_s),
        .entry_valid_o (entry_valid_s),
        .entry_reg_o   (entry_reg_s)
    );

    // Grant decision; alu_ready depends only on registered state.
    always_comb begin
        force_md_s = (starve_q == SCNT_W'(STARVE_LIMIT)) && !fifo_empty_s;
        alu_ready  = !force_md_s;
        grant_s    = GNT_NONE;
        if (force_md_s) begin
            grant_s = GNT_MD;
        end else if (alu_valid) begin
            grant_s = GNT_ALU;
        end else if (!fifo_empty_s) begin
            grant_s = GNT_MD;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Starvation counter: counts ALU wins while the FIFO waits.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty_s || (grant_s == GNT_MD)) begin
            starve_d = SCNT_W'(0);
        end else if (grant_s == GNT_ALU) begin
            if (starve_q == SCNT_W'(STARVE_LIMIT)) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + SCNT_W'(1);
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Write-port next state; r0 destinations are consumed without a write.
    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        case (grant_s)
            GNT_ALU: begin
                we_d    = (alu_reg != REG_W'(0));
                wreg_d  = alu_reg;
                wdata_d = alu_data;
            end
            GNT_MD: begin
                we_d    = (head_s.wr_reg != REG_W'(0));
                wreg_d  = head_s.wr_reg;
                wdata_d = head_s.data;
            end
            default: begin
                we_d    = 1'b0;
                wreg_d  = wreg_q;
                wdata_d = wdata_q;
            end
        endcase
    end

    // Registered write port and starvation counter.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            starve_q <= SCNT_W'(0);
            we_q     <= 1'b0;
            wreg_q   <= REG_W'(0);
            wdata_q  <= DATA_W'(0);
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

    // Hazard mask over occupied FIFO slots; r0 is never a hazard.
    always_comb begin
        pending_mask = NUM_REGS'(0);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i]) begin
                pending_mask = pending_mask | reg_onehot(entry_reg_s[i]);
            end else begin
                pending_mask = pending_mask;
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed stimulus; expected register-file writes are queued when the
// stimulus is issued and a monitor pops/compares every asserted write.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

    logic        clock;
    logic        ctrl_reset_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    writeback_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_reg          (alu_reg),
        .alu_data         (alu_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pending_mask     (pending_mask),
        .fifo_count       (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every asserted write must match the queue head.
    always @(negedge clock) begin
        exp_t e;
        if (ctrl_reset_n && ctrl_writeEnable) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got reg=%0d data=0x%08h, required no write",
                         ctrl_writeReg, data_writeReg);
            end else begin
                e = exp_q.pop_front();
                if (ctrl_writeReg !== e.r || data_writeReg !== e.d) begin
                    n_errors++;
                    $display("FAIL wb_write: got reg=%0d data=0x%08h, required reg=%0d data=0x%08h",
                             ctrl_writeReg, data_writeReg, e.r, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] md_regs [5];
        int         k;
        int         m;
        logic       exp_rdy;

        md_regs[0] = 5'd1; md_regs[1] = 5'd2; md_regs[2] = 5'd3;
        md_regs[3] = 5'd4; md_regs[4] = 5'd12;

        ctrl_reset_n = 1'b0;
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
        md_valid  = 1'b0; md_reg  = 5'd0; md_data  = 32'd0;

        // Reset held while valids are driven.
        @(negedge clock);
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h1111_1111;
        md_valid  = 1'b1; md_reg  = 5'd3; md_data  = 32'h2222_2222;
        repeat (3) @(negedge clock);
        chk("rst_we",        32'(ctrl_writeEnable), 32'd0);
        chk("rst_count",     32'(fifo_count),       32'd0);
        chk("rst_mask",      pending_mask,          32'd0);
        chk("rst_alu_ready", 32'(alu_ready),        32'd1);
        chk("rst_md_ready",  32'(md_ready),         32'd1);
        alu_valid = 1'b0; md_valid = 1'b0;
        ctrl_reset_n = 1'b1;
        @(negedge clock);

        // ALU only, then ALU to r0.
        chk("alu_ready_idle", 32'(alu_ready), 32'd1);
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEAD_BEEF;
        expect_write(5'd5, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("alu_we",   32'(ctrl_writeEnable), 32'd1);
        chk("alu_reg",  32'(ctrl_writeReg),    32'd5);
        chk("alu_data", data_writeReg,         32'hDEAD_BEEF);
        alu_reg = 5'd0; alu_data = 32'h1234_5678;
        @(negedge clock);
        chk("alu_r0_no_write", 32'(ctrl_writeEnable), 32'd0);
        alu_valid = 1'b0;
        @(negedge clock);

        // Fill with ALU busy, overflow attempt, then starvation pattern.
        // Forced multdiv slots fall on cycles 4, 8, 12, 16, 20.
        k = 0;
        m = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 4) begin
                chk("full_count",    32'(fifo_count), 32'd4);
                chk("full_md_ready", 32'(md_ready),   32'd0);
                chk("full_mask",     pending_mask,    32'h0000_001E);
            end else if (i == 5) begin
                chk("pop_count",    32'(fifo_count), 32'd3);
                chk("pop_md_ready", 32'(md_ready),   32'd1);
                chk("pop_mask",     pending_mask,    32'h0000_001C);
            end else if (i == 6) begin
                chk("refill_count", 32'(fifo_count), 32'd4);
                chk("refill_mask",  pending_mask,    32'h0000_101C);
            end
            exp_rdy = !((i == 4) || (i == 8) || (i == 12) || (i == 16) || (i == 20));
            chk($sformatf("starve_alu_ready_c%0d", i), 32'(alu_ready), 32'(exp_rdy));

            if (i < 4) begin
                md_valid = 1'b1; md_reg = 5'(i + 1);
            end else if (i < 6) begin
                md_valid = 1'b1; md_reg = 5'd12;
            end else begin
                md_valid = 1'b0;
            end
            md_data = 32'hB000_0000 + 32'(md_reg);

            alu_valid = 1'b1;
            alu_reg   = 5'(10 + k);
            alu_data  = 32'hA000_0000 + 32'(k);
            if (exp_rdy) begin
                expect_write(5'(10 + k), 32'hA000_0000 + 32'(k));
                k++;
            end else begin
                expect_write(md_regs[m], 32'hB000_0000 + 32'(md_regs[m]));
                m++;
            end
            @(negedge clock);
        end
        alu_valid = 1'b0; md_valid = 1'b0;
        chk("drain_count", 32'(fifo_count), 32'd0);
        chk("drain_mask",  pending_mask,    32'd0);
        @(negedge clock);

        // Multdiv write to r0: queued, popped, never written, never pending.
        md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h5555_5555;
        @(negedge clock);
        md_valid = 1'b0;
        chk("md_r0_count", 32'(fifo_count), 32'd1);
        chk("md_r0_mask",  pending_mask,    32'd0);
        @(negedge clock);
        chk("md_r0_no_write", 32'(ctrl_writeEnable), 32'd0);
        chk("md_r0_popped",   32'(fifo_count),       32'd0);

        // Minimum multdiv latency.
        md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h9999_0009;
        expect_write(5'd9, 32'h9999_0009);
        @(negedge clock);
        md_valid = 1'b0;
        chk("lat_mask_n1", pending_mask,          32'h0000_0200);
        chk("lat_we_n1",   32'(ctrl_writeEnable), 32'd0);
        @(negedge clock);
        chk("lat_we_n2",   32'(ctrl_writeEnable), 32'd1);
        chk("lat_reg_n2",  32'(ctrl_writeReg),    32'd9);
        chk("lat_mask_n2", pending_mask,          32'd0);

        // Reset asserted mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_reg = 5'(20 + i); alu_data = 32'hC000_0000 + 32'(i);
            expect_write(5'(20 + i), 32'hC000_0000 + 32'(i));
            md_valid = 1'b1; md_reg = 5'(5 + i); md_data = 32'hD000_0000 + 32'(i);
            @(negedge clock);
        end
        alu_valid = 1'b0; md_valid = 1'b0;
        chk("mid_count_before", 32'(fifo_count), 32'd3);
        chk("mid_mask_before",  pending_mask,    32'h0000_00E0);
        #2 ctrl_reset_n = 1'b0;
        #1;
        chk("mid_rst_count",     32'(fifo_count),       32'd0);
        chk("mid_rst_mask",      pending_mask,          32'd0);
        chk("mid_rst_we",        32'(ctrl_writeEnable), 32'd0);
        chk("mid_rst_md_ready",  32'(md_ready),         32'd1);
        chk("mid_rst_alu_ready", 32'(alu_ready),        32'd1);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
